// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM between a write requester (i_wr_*/o_wr_ack) and a read requester (i_rd_*/o_rd_*), sequencing o_SRAM_* strobes and io_SRAM_DQ with alternating grants under contention
module sram_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 16,
  parameter int WR_PULSE_CYC = 1,
  parameter int RD_WAIT_CYC  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);
  localparam int MAX_CYC = WR_PULSE_CYC > RD_WAIT_CYC ? WR_PULSE_CYC : RD_WAIT_CYC;
  localparam int CNT_W = $clog2(MAX_CYC + 1);
  typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_ADDR, R_DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, rd_q;
  logic last_wr, grant_wr, grant_rd, cnt_done, drive;
  always_comb begin
    grant_wr = i_wr_req && (!i_rd_req || !last_wr);
    grant_rd = i_rd_req && !grant_wr;
    cnt_done = cnt == CNT_W'(state == W_PULSE ? WR_PULSE_CYC - 1 : RD_WAIT_CYC - 1);
    state_n = state;
    unique case (state)
      IDLE:    state_n = grant_wr ? W_SETUP : grant_rd ? R_ADDR : IDLE;
      W_SETUP: state_n = W_PULSE;
      W_PULSE: state_n = cnt_done ? W_HOLD : W_PULSE;
      W_HOLD:  state_n = IDLE;
      R_ADDR:  state_n = cnt_done ? R_DONE : R_ADDR;
      default: state_n = IDLE;
    endcase
  end
  // cnt measures dwell time in the current state and restarts on every transition
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      last_wr <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= state_n == state ? cnt + 1'b1 : '0;
      if (state == IDLE && (grant_wr || grant_rd)) begin
        addr_q  <= grant_wr ? i_wr_addr : i_rd_addr;
        last_wr <= grant_wr;
      end
      if (state == IDLE && grant_wr) data_q <= i_wr_data;
      if (state == R_ADDR && cnt_done) rd_q <= io_SRAM_DQ;
    end
  end
  assign drive       = state == W_SETUP || state == W_PULSE || state == W_HOLD;
  assign io_SRAM_DQ  = drive ? data_q : {DATA_W{1'bz}};
  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_WE_N = state != W_PULSE;
  assign o_SRAM_OE_N = state != R_ADDR;
  assign o_SRAM_CE_N = 1'b0;
  assign o_SRAM_LB_N = 1'b0;
  assign o_SRAM_UB_N = 1'b0;
  assign o_wr_ack    = state == W_HOLD;
  assign o_rd_valid  = state == R_DONE;
  assign o_busy      = state != IDLE;
  assign o_rd_data   = rd_q;
endmodule
